// File: rtl/tone_capture.sv
// tone_capture: measures a square-wave tone input and turns each steady run of periods
// into a {period, duration} note event in clk-cycle units.
// Optional build macro: TONE_CAPTURE_PERIOD_AVG_EN
//   When defined, the reported period is the truncated mean of the last four matching
//   periods, or ref if fewer than four have been seen.
//   When undefined, the reported period is ref, the period that started the run.
//
//   state   | meaning
//   IDLE    | no tone seen; waiting for the first rising edge
//   ACQUIRE | collecting matching periods toward lock
//   LOCKED  | note locked; extends the note until a different period arrives or silence
module tone_capture #(
   parameter int unsigned MIN_PERIOD = 64,
   parameter int unsigned MAX_PERIOD = 65535,
   parameter int unsigned TOL        = 8,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tone_in,
   input  logic        note_ready,
   output logic        note_valid,
   output logic [31:0] note_period,
   output logic [31:0] note_duration,
   output logic        locked,
   output logic        overflow
);

   localparam logic [31:0] CNT_SAT = 32'(MAX_PERIOD) + 32'd1;
   localparam logic [15:0] LOCK_N  = 16'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state;
   logic        sync1, sync2, sync3, edge_q;
   logic [31:0] period_cnt, dur_cnt, ref_p, last_dur;
   logic [15:0] match_cnt;
   logic [31:0] p, diff, dur_inc, emit_period;
   logic        timeout, p_glitch, p_bad, p_match;
   logic        acq_edge, lck_edge, is_match, is_new, emit;

   // Measured period at an edge and its classification against ref.
   assign p        = period_cnt + 32'd1;
   assign diff     = (p >= ref_p) ? (p - ref_p) : (ref_p - p);
   assign dur_inc  = (dur_cnt == '1) ? dur_cnt : dur_cnt + 32'd1;
   assign timeout  = (period_cnt == CNT_SAT);
   assign p_glitch = (p < MIN_PERIOD);
   assign p_bad    = p_glitch || (p > MAX_PERIOD);
   assign p_match  = (diff <= TOL);

   // A coincident timeout wins over an edge; glitch edges are invisible while locked.
   assign acq_edge = (state == ACQUIRE) && edge_q && !timeout;
   assign lck_edge = (state == LOCKED) && edge_q && !timeout && !p_glitch;
   assign is_match = (acq_edge && !p_bad && p_match) || (lck_edge && p_match);
   assign is_new   = (acq_edge && !p_bad && !p_match) || (lck_edge && !p_match);
   assign emit     = (state == LOCKED) && (timeout || (lck_edge && !p_match));

   // Two-flop synchroniser plus registered rising-edge pulse (3 clk pin-to-pulse).
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync1  <= tone_in;
         sync2  <= sync1;
         sync3  <= sync2;
         edge_q <= sync2 & ~sync3;
      end
   end

   // Note tracking FSM with its period/duration counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         locked     <= 1'b0;
         ref_p      <= '0;
         match_cnt  <= '0;
         period_cnt <= '0;
         dur_cnt    <= '0;
         last_dur   <= '0;
      end else begin
         period_cnt <= timeout ? period_cnt : period_cnt + 32'd1;
         dur_cnt    <= dur_inc;
         if (is_match)
            last_dur <= dur_inc;
         case (state)
            IDLE: begin
               if (edge_q) begin
                  state      <= ACQUIRE;
                  ref_p      <= '0;
                  match_cnt  <= '0;
                  dur_cnt    <= '0;
                  period_cnt <= '0;
               end
            end
            ACQUIRE: begin
               if (timeout) begin
                  state <= IDLE;
               end else if (edge_q) begin
                  period_cnt <= '0;
                  if (p_bad) begin
                     ref_p     <= '0;
                     match_cnt <= '0;
                  end else if (p_match) begin
                     match_cnt <= match_cnt + 16'd1;
                     if (match_cnt + 16'd1 >= LOCK_N) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     // This run began at the previous edge, so its duration starts at p.
                     ref_p     <= p;
                     match_cnt <= 16'd1;
                     dur_cnt   <= p;
                  end
               end
            end
            LOCKED: begin
               if (timeout) begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end else if (lck_edge) begin
                  period_cnt <= '0;
                  if (!p_match) begin
                     state     <= ACQUIRE;
                     locked    <= 1'b0;
                     ref_p     <= p;
                     match_cnt <= 16'd1;
                     dur_cnt   <= p;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

`ifdef TONE_CAPTURE_PERIOD_AVG_EN
   logic [31:0] hist0, hist1, hist2, hist3;
   logic [2:0]  hist_cnt;
   logic [33:0] hist_sum;

   assign hist_sum    = {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, hist3};
   assign emit_period = (hist_cnt == 3'd4) ? hist_sum[33:2] : ref_p;

   // History of the most recent matching periods of the current run.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist0    <= '0;
         hist1    <= '0;
         hist2    <= '0;
         hist3    <= '0;
         hist_cnt <= '0;
      end else if ((state == IDLE) && edge_q) begin
         hist_cnt <= '0;
      end else if (is_new) begin
         hist0    <= p;
         hist_cnt <= 3'd1;
      end else if (is_match) begin
         hist0 <= p;
         hist1 <= hist0;
         hist2 <= hist1;
         hist3 <= hist2;
         if (hist_cnt != 3'd4)
            hist_cnt <= hist_cnt + 3'd1;
      end
   end
`else
   assign emit_period = ref_p;
`endif

   // Single-entry output slot with ready/valid handshake and drop-on-full.
   always_ff @(posedge clk) begin
      if (reset) begin
         note_valid    <= 1'b0;
         note_period   <= '0;
         note_duration <= '0;
         overflow      <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (emit) begin
            if (note_valid && !note_ready) begin
               overflow <= 1'b1;
            end else begin
               note_valid    <= 1'b1;
               note_period   <= emit_period;
               note_duration <= last_dur;
            end
         end else if (note_valid && note_ready) begin
            note_valid <= 1'b0;
         end
      end
   end

endmodule
